// File: rtl/btn_debounce_if.sv
// Button debouncer signal bundle: raw button level in, debounced level and event pulses out.
// The master drives the raw button; the slave is the debouncer itself.
interface btn_debounce_if;
   logic btn_in;
   logic btn_level;
   logic press;
   logic release_pulse;
   logic rpt;

   modport master (
      output btn_in,
      input  btn_level,
      input  press,
      input  release_pulse,
      input  rpt
   );

   modport slave (
      input  btn_in,
      output btn_level,
      output press,
      output release_pulse,
      output rpt
   );
endinterface

// File: rtl/btn_debounce.sv
// Pushbutton debouncer: two-flop synchronizer, four-state stability FSM with
// registered level/press/release outputs and optional auto-repeat while held.
module btn_debounce #(
   parameter logic [24:0] STABLE_CYCLES = 25'd120000,
   parameter logic        REPEAT_EN     = 1'b0,
   parameter logic [24:0] REPEAT_DELAY  = 25'd6000000,
   parameter logic [24:0] REPEAT_PERIOD = 25'd1200000
) (
   input  logic          clk,
   input  logic          rst,
   btn_debounce_if.slave if_btn
);

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      PRESS_CHK   = 2'd1,
      HELD        = 2'd2,
      RELEASE_CHK = 2'd3
   } state_t;

   localparam logic [24:0] STAB_LAST       = STABLE_CYCLES - 25'd1;
   localparam logic [24:0] RPT_DELAY_LAST  = REPEAT_DELAY - 25'd1;
   localparam logic [24:0] RPT_PERIOD_LAST = REPEAT_PERIOD - 25'd1;

   state_t      r_state;
   state_t      w_state_next;
   logic        r_sync1;
   logic        r_btn_s;
   logic [24:0] r_stab_cnt;
   logic [24:0] w_stab_cnt_next;
   logic        r_level;
   logic        w_level_next;
   logic        r_press;
   logic        w_press_next;
   logic        r_release;
   logic        w_release_next;

   logic [24:0] r_rpt_cnt;
   logic        r_rpt_first;
   logic        r_rpt;
   logic [24:0] w_rpt_limit;
   logic        w_rpt_run;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 1'b0;
         r_btn_s <= 1'b0;
      end else begin
         r_sync1 <= if_btn.btn_in;
         r_btn_s <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= RELEASED;
         r_stab_cnt <= 25'd0;
         r_level    <= 1'b0;
         r_press    <= 1'b0;
         r_release  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_stab_cnt <= w_stab_cnt_next;
         r_level    <= w_level_next;
         r_press    <= w_press_next;
         r_release  <= w_release_next;
      end
   end

   // The stability counter stops at STAB_LAST; the transition fires from there.
   always_comb begin
      w_state_next    = r_state;
      w_stab_cnt_next = r_stab_cnt;
      w_level_next    = r_level;
      w_press_next    = 1'b0;
      w_release_next  = 1'b0;
      case (r_state)
         RELEASED: begin
            if (r_btn_s) begin
               w_state_next    = PRESS_CHK;
               w_stab_cnt_next = 25'd0;
            end
         end
         PRESS_CHK: begin
            if (!r_btn_s) begin
               w_state_next = RELEASED;
            end else if (r_stab_cnt == STAB_LAST) begin
               w_state_next = HELD;
               w_level_next = 1'b1;
               w_press_next = 1'b1;
            end else begin
               w_stab_cnt_next = r_stab_cnt + 25'd1;
            end
         end
         HELD: begin
            if (!r_btn_s) begin
               w_state_next    = RELEASE_CHK;
               w_stab_cnt_next = 25'd0;
            end
         end
         RELEASE_CHK: begin
            if (r_btn_s) begin
               w_state_next = HELD;
            end else if (r_stab_cnt == STAB_LAST) begin
               w_state_next   = RELEASED;
               w_level_next   = 1'b0;
               w_release_next = 1'b1;
            end else begin
               w_stab_cnt_next = r_stab_cnt + 25'd1;
            end
         end
         default: begin
            w_state_next = RELEASED;
         end
      endcase
   end

   // Repeat timing only advances while held with the synchronized button still down;
   // a falling sample freezes it until the release check resolves.
   assign w_rpt_limit = r_rpt_first ? RPT_DELAY_LAST : RPT_PERIOD_LAST;
   assign w_rpt_run   = REPEAT_EN && (r_state == HELD) && r_btn_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rpt_cnt   <= 25'd0;
         r_rpt_first <= 1'b1;
         r_rpt       <= 1'b0;
      end else begin
         r_rpt <= 1'b0;
         if (w_press_next || (w_state_next == RELEASED)) begin
            r_rpt_cnt   <= 25'd0;
            r_rpt_first <= 1'b1;
         end else if (w_rpt_run) begin
            if (r_rpt_cnt == w_rpt_limit) begin
               r_rpt       <= 1'b1;
               r_rpt_cnt   <= 25'd0;
               r_rpt_first <= 1'b0;
            end else begin
               r_rpt_cnt <= r_rpt_cnt + 25'd1;
            end
         end
      end
   end

   assign if_btn.btn_level     = r_level;
   assign if_btn.press         = r_press;
   assign if_btn.release_pulse = r_release;
   assign if_btn.rpt           = REPEAT_EN & r_rpt;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: three instances (S=4 no repeat, S=1, S=4 with repeat)
// share one raw button and reset; each task checks hand-derived per-edge outputs.
module tb_btn_debounce;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn = 1'b0;
   int   vec_cnt = 0;
   int   err_cnt = 0;

   always #5 clk = ~clk;

   btn_debounce_if if_a ();
   btn_debounce_if if_s1 ();
   btn_debounce_if if_r ();

   assign if_a.btn_in  = btn;
   assign if_s1.btn_in = btn;
   assign if_r.btn_in  = btn;

   btn_debounce #(
      .STABLE_CYCLES (25'd4),
      .REPEAT_EN     (1'b0),
      .REPEAT_DELAY  (25'd8),
      .REPEAT_PERIOD (25'd3)
   ) dut_a (
      .clk    (clk),
      .rst    (rst),
      .if_btn (if_a)
   );

   btn_debounce #(
      .STABLE_CYCLES (25'd1),
      .REPEAT_EN     (1'b0),
      .REPEAT_DELAY  (25'd8),
      .REPEAT_PERIOD (25'd3)
   ) dut_s1 (
      .clk    (clk),
      .rst    (rst),
      .if_btn (if_s1)
   );

   btn_debounce #(
      .STABLE_CYCLES (25'd4),
      .REPEAT_EN     (1'b1),
      .REPEAT_DELAY  (25'd8),
      .REPEAT_PERIOD (25'd3)
   ) dut_r (
      .clk    (clk),
      .rst    (rst),
      .if_btn (if_r)
   );

   // Observed bundles, bit order {press, release, level, rpt}.
   logic [3:0] obs_a, obs_s1, obs_r;
   assign obs_a  = {if_a.press,  if_a.release_pulse,  if_a.btn_level,  if_a.rpt};
   assign obs_s1 = {if_s1.press, if_s1.release_pulse, if_s1.btn_level, if_s1.rpt};
   assign obs_r  = {if_r.press,  if_r.release_pulse,  if_r.btn_level,  if_r.rpt};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      btn = 1'b0;
      repeat (3) tick();
      vec_cnt += 3;
      if (obs_a !== 4'b0000) begin err_cnt++; $display("FAIL reset_held dut_a got %b exp 0000", obs_a); end
      if (obs_s1 !== 4'b0000) begin err_cnt++; $display("FAIL reset_held dut_s1 got %b exp 0000", obs_s1); end
      if (obs_r !== 4'b0000) begin err_cnt++; $display("FAIL reset_held dut_r got %b exp 0000", obs_r); end
      rst = 1'b1;
      repeat (2) tick();
      vec_cnt += 3;
      if (obs_a !== 4'b0000) begin err_cnt++; $display("FAIL reset_exit dut_a got %b exp 0000", obs_a); end
      if (obs_s1 !== 4'b0000) begin err_cnt++; $display("FAIL reset_exit dut_s1 got %b exp 0000", obs_s1); end
      if (obs_r !== 4'b0000) begin err_cnt++; $display("FAIL reset_exit dut_r got %b exp 0000", obs_r); end
      $display("test_reset done, vectors so far %0d", vec_cnt);
   endtask

   task automatic test_clean_press();
      logic [3:0] ea, e1, er;
      for (int k = 1; k <= 20; k++) begin
         btn = 1'b1;
         tick();
         ea = {k == 7, 1'b0, k >= 7, 1'b0};
         e1 = {k == 4, 1'b0, k >= 4, 1'b0};
         er = {k == 7, 1'b0, k >= 7, (k == 15) || (k == 18)};
         vec_cnt += 3;
         if (obs_a !== ea) begin err_cnt++; $display("FAIL clean_press dut_a k=%0d got %b exp %b", k, obs_a, ea); end
         if (obs_s1 !== e1) begin err_cnt++; $display("FAIL clean_press dut_s1 k=%0d got %b exp %b", k, obs_s1, e1); end
         if (obs_r !== er) begin err_cnt++; $display("FAIL clean_press dut_r k=%0d got %b exp %b", k, obs_r, er); end
      end
      $display("test_clean_press done, vectors so far %0d", vec_cnt);
   endtask

   task automatic test_release_bounce();
      logic [3:0] ea, e1, er;
      for (int k = 1; k <= 14; k++) begin
         btn = (k == 3);
         tick();
         ea = {1'b0, k == 10, k < 10, 1'b0};
         e1 = {1'b0, k == 4, k < 4, 1'b0};
         er = {1'b0, k == 10, k < 10, k == 1};
         vec_cnt += 3;
         if (obs_a !== ea) begin err_cnt++; $display("FAIL release_bounce dut_a k=%0d got %b exp %b", k, obs_a, ea); end
         if (obs_s1 !== e1) begin err_cnt++; $display("FAIL release_bounce dut_s1 k=%0d got %b exp %b", k, obs_s1, e1); end
         if (obs_r !== er) begin err_cnt++; $display("FAIL release_bounce dut_r k=%0d got %b exp %b", k, obs_r, er); end
      end
      $display("test_release_bounce done, vectors so far %0d", vec_cnt);
   endtask

   task automatic test_glitch();
      logic [3:0] e1;
      for (int k = 1; k <= 12; k++) begin
         btn = (k <= 3);
         tick();
         e1 = {k == 4, k == 7, (k >= 4) && (k <= 6), 1'b0};
         vec_cnt += 3;
         if (obs_a !== 4'b0000) begin err_cnt++; $display("FAIL glitch dut_a k=%0d got %b exp 0000", k, obs_a); end
         if (obs_s1 !== e1) begin err_cnt++; $display("FAIL glitch dut_s1 k=%0d got %b exp %b", k, obs_s1, e1); end
         if (obs_r !== 4'b0000) begin err_cnt++; $display("FAIL glitch dut_r k=%0d got %b exp 0000", k, obs_r); end
      end
      $display("test_glitch done, vectors so far %0d", vec_cnt);
   endtask

   task automatic test_repeat();
      logic [3:0] ea, e1, er;
      logic       rpt_exp;
      for (int k = 1; k <= 50; k++) begin
         btn = (k <= 36);
         tick();
         rpt_exp = (k >= 15) && (k <= 36) && (((k - 15) % 3) == 0);
         ea = {k == 7, k == 43, (k >= 7) && (k < 43), 1'b0};
         e1 = {k == 4, k == 40, (k >= 4) && (k < 40), 1'b0};
         er = {k == 7, k == 43, (k >= 7) && (k < 43), rpt_exp};
         vec_cnt += 3;
         if (obs_a !== ea) begin err_cnt++; $display("FAIL repeat dut_a k=%0d got %b exp %b", k, obs_a, ea); end
         if (obs_s1 !== e1) begin err_cnt++; $display("FAIL repeat dut_s1 k=%0d got %b exp %b", k, obs_s1, e1); end
         if (obs_r !== er) begin err_cnt++; $display("FAIL repeat dut_r k=%0d got %b exp %b", k, obs_r, er); end
      end
      $display("test_repeat done, vectors so far %0d", vec_cnt);
   endtask

   task automatic test_reset_mid_check();
      logic [3:0] ea, e1, er;
      for (int k = 1; k <= 20; k++) begin
         btn = 1'b1;
         tick();
         ea = {k == 12, 1'b0, k >= 12, 1'b0};
         e1 = {k == 9, 1'b0, k >= 9, 1'b0};
         er = {k == 12, 1'b0, k >= 12, k == 20};
         vec_cnt += 3;
         if (obs_a !== ea) begin err_cnt++; $display("FAIL reset_mid dut_a k=%0d got %b exp %b", k, obs_a, ea); end
         if (obs_s1 !== e1) begin err_cnt++; $display("FAIL reset_mid dut_s1 k=%0d got %b exp %b", k, obs_s1, e1); end
         if (obs_r !== er) begin err_cnt++; $display("FAIL reset_mid dut_r k=%0d got %b exp %b", k, obs_r, er); end
         if (k == 3) begin
            rst = 1'b0;
            #1;
            vec_cnt += 3;
            if (obs_a !== 4'b0000) begin err_cnt++; $display("FAIL reset_mid_async dut_a got %b exp 0000", obs_a); end
            if (obs_s1 !== 4'b0000) begin err_cnt++; $display("FAIL reset_mid_async dut_s1 got %b exp 0000", obs_s1); end
            if (obs_r !== 4'b0000) begin err_cnt++; $display("FAIL reset_mid_async dut_r got %b exp 0000", obs_r); end
         end
         if (k == 5) rst = 1'b1;
      end
      // All instances hold level=1 here; reset must clear it without a clock edge.
      rst = 1'b0;
      #1;
      vec_cnt += 3;
      if (obs_a !== 4'b0000) begin err_cnt++; $display("FAIL reset_async_held dut_a got %b exp 0000", obs_a); end
      if (obs_s1 !== 4'b0000) begin err_cnt++; $display("FAIL reset_async_held dut_s1 got %b exp 0000", obs_s1); end
      if (obs_r !== 4'b0000) begin err_cnt++; $display("FAIL reset_async_held dut_r got %b exp 0000", obs_r); end
      btn = 1'b0;
      tick();
      rst = 1'b1;
      repeat (4) tick();
      $display("test_reset_mid_check done, vectors so far %0d", vec_cnt);
   endtask

   task automatic test_random_bounce();
      logic lvl;
      logic track_a;
      int   blen;
      int   n_press;
      int   n_rel;
      track_a = 1'b0;
      n_press = 0;
      n_rel   = 0;
      for (int s = 0; s < 8; s++) begin
         lvl  = ((s % 2) == 0);
         blen = int'($urandom_range(1, 3));
         for (int b = 0; b < blen + 12; b++) begin
            btn = (b < blen) ? 1'($urandom_range(0, 1)) : lvl;
            tick();
            vec_cnt += 2;
            if ((int'(if_a.press) + int'(if_a.release_pulse) + int'(if_a.rpt)) > 1) begin
               err_cnt++; $display("FAIL random_exclusive dut_a seg=%0d got %b exp at most one pulse", s, obs_a);
            end
            if ((int'(if_r.press) + int'(if_r.release_pulse) + int'(if_r.rpt)) > 1) begin
               err_cnt++; $display("FAIL random_exclusive dut_r seg=%0d got %b exp at most one pulse", s, obs_r);
            end
            if (if_a.press) begin
               vec_cnt++;
               if (track_a !== 1'b0) begin err_cnt++; $display("FAIL random_alternate press seg=%0d got press while pressed exp release first", s); end
               track_a = 1'b1;
               n_press++;
            end
            if (if_a.release_pulse) begin
               vec_cnt++;
               if (track_a !== 1'b1) begin err_cnt++; $display("FAIL random_alternate release seg=%0d got release while released exp press first", s); end
               track_a = 1'b0;
               n_rel++;
            end
         end
         vec_cnt += 2;
         if (if_a.btn_level !== lvl) begin err_cnt++; $display("FAIL random_level dut_a seg=%0d got %b exp %b", s, if_a.btn_level, lvl); end
         if (if_r.btn_level !== lvl) begin err_cnt++; $display("FAIL random_level dut_r seg=%0d got %b exp %b", s, if_r.btn_level, lvl); end
      end
      vec_cnt += 2;
      if (n_press != 4) begin err_cnt++; $display("FAIL random_press_count got %0d exp 4", n_press); end
      if (n_rel != 4) begin err_cnt++; $display("FAIL random_release_count got %0d exp 4", n_rel); end
      $display("test_random_bounce done, vectors so far %0d", vec_cnt);
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_release_bounce();
      test_glitch();
      test_repeat();
      test_reset_mid_check();
      test_random_bounce();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp bench completion");
      $fatal(1, "watchdog expired");
   end

endmodule
